// File: rtl/stream_pkg.sv
// Shared types for the stream_tools pixel stages.
//   pixel_t        : one 24-bit RGB pixel
//   tagged_pixel_t : pixel plus start-of-frame / end-of-line / end-of-frame tags
//   framer_state_t : frame-gating FSM states
package stream_pkg;

    localparam int unsigned PIXEL_WIDTH = 24;

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;

    typedef struct packed {
        pixel_t data;
        logic   sof;
        logic   eol;
        logic   eof;
    } tagged_pixel_t;

    localparam int unsigned TAGGED_WIDTH = $bits(tagged_pixel_t);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } framer_state_t;

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry skid buffer with a registered input ready.
//   in_data/in_valid/in_ready   : upstream handshake (in_ready is a flop)
//   in_ready_next_c             : value in_ready takes next cycle
//   out_data/out_valid/out_ready: downstream handshake (out_* are flops)
//   count / count_next_c        : occupancy now / next cycle (0..2)
module stream_skid_buffer #(
    parameter int unsigned WIDTH = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             in_ready_next_c,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       count,
    output logic [1:0]       count_next_c
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             push, pop;

    // Output slot is refilled from the skid slot first so order is preserved.
    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        push         = in_valid && in_ready_q;
        pop          = out_valid_q && out_ready;

        if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = push;
                if (push) begin
                    skid_data_d = in_data;
                end
            end else begin
                out_valid_d = push;
                if (push) begin
                    out_data_d = in_data;
                end
            end
        end else if (push) begin
            skid_data_d  = in_data;
            skid_valid_d = 1'b1;
        end

        // Skid slot occupied implies output slot occupied, so full == skid valid.
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign in_ready_next_c = in_ready_d;
    assign out_data        = out_data_q;
    assign out_valid       = out_valid_q;
    assign count           = 2'(out_valid_q) + 2'(skid_valid_q);
    assign count_next_c    = 2'(out_valid_d) + 2'(skid_valid_d);

endmodule

// File: rtl/stream_pixel_framer.sv
// Frames a 24-bit pixel stream against a run-time cols x rows geometry.
//   cfg_cols/cfg_rows/cfg_start : frame request, sampled in IDLE only
//   busy / frame_done           : frame in progress / last beat has left
//   stream_in*                  : upstream pixels, accepted for one frame only
//   stream_out*                 : registered tagged pixels with sof/eol/eof
module stream_pixel_framer
    import stream_pkg::*;
#(
    parameter int unsigned COL_WIDTH = 12,
    parameter int unsigned ROW_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COL_WIDTH-1:0] cfg_cols,
    input  logic [ROW_WIDTH-1:0] cfg_rows,
    input  logic                 cfg_start,
    output logic                 busy,
    output logic                 frame_done,
    input  logic [23:0]          stream_in,
    input  logic                 stream_in_valid,
    output logic                 stream_in_ready,
    output logic [23:0]          stream_out,
    output logic                 stream_out_sof,
    output logic                 stream_out_eol,
    output logic                 stream_out_eof,
    output logic                 stream_out_valid,
    input  logic                 stream_out_ready
);

    framer_state_t        state_q, state_d;
    logic [COL_WIDTH-1:0] cols_q, cols_d, col_q, col_d;
    logic [ROW_WIDTH-1:0] rows_q, rows_d, row_q, row_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic                 in_ready_q, in_ready_d;

    logic                    cfg_ok, accept, sof, eol, eof;
    tagged_pixel_t           in_beat, out_beat;
    logic [TAGGED_WIDTH-1:0] skid_out_data;
    logic                    skid_in_ready, skid_in_ready_next_c;
    logic [1:0]              skid_count, skid_count_next_c;

    // Tags come from the counters before this pixel's increment.
    always_comb begin
        cfg_ok       = cfg_start && (cfg_cols != '0) && (cfg_rows != '0);
        accept       = stream_in_valid && in_ready_q && skid_in_ready;
        sof          = (col_q == '0) && (row_q == '0);
        eol          = (col_q == cols_q - COL_WIDTH'(1));
        eof          = eol && (row_q == rows_q - ROW_WIDTH'(1));
        in_beat.data = stream_in;
        in_beat.sof  = sof;
        in_beat.eol  = eol;
        in_beat.eof  = eof;
    end

    stream_skid_buffer #(
        .WIDTH (TAGGED_WIDTH)
    ) u_skid (
        .clk             (clk),
        .rst             (rst),
        .in_data         (in_beat),
        .in_valid        (accept),
        .in_ready        (skid_in_ready),
        .in_ready_next_c (skid_in_ready_next_c),
        .out_data        (skid_out_data),
        .out_valid       (stream_out_valid),
        .out_ready       (stream_out_ready),
        .count           (skid_count),
        .count_next_c    (skid_count_next_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; DRAIN is held through the frame_done cycle so a
    // coincident cfg_start is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_ok) state_d = RUN;
            RUN:     if (accept && eof) state_d = DRAIN;
            DRAIN:   if (frame_done_q && (skid_count == 2'd0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs; frame_done fires the cycle after the buffer empties.
    always_comb begin
        frame_done_d = (state_q == DRAIN) && !frame_done_q && (skid_count_next_c == 2'd0);
        busy_d       = (state_d != IDLE) && !frame_done_d;
        in_ready_d   = (state_d == RUN) && skid_in_ready_next_c;
    end

    // Geometry latches and position counters.
    always_comb begin
        cols_d = cols_q;
        rows_d = rows_q;
        col_d  = col_q;
        row_d  = row_q;
        if ((state_q == IDLE) && cfg_ok) begin
            cols_d = cfg_cols;
            rows_d = cfg_rows;
            col_d  = '0;
            row_d  = '0;
        end else if (accept) begin
            if (eol) begin
                col_d = '0;
                row_d = eof ? '0 : row_q + ROW_WIDTH'(1);
            end else begin
                col_d = col_q + COL_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cols_q       <= '0;
            rows_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            cols_q       <= cols_d;
            rows_q       <= rows_d;
            col_q        <= col_d;
            row_q        <= row_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign out_beat        = tagged_pixel_t'(skid_out_data);
    assign stream_out      = out_beat.data;
    assign stream_out_sof  = out_beat.sof;
    assign stream_out_eol  = out_beat.eol;
    assign stream_out_eof  = out_beat.eof;
    assign busy            = busy_q;
    assign frame_done      = frame_done_q;
    assign stream_in_ready = in_ready_q;

endmodule

// File: tb/tb_stream_pixel_framer.sv
// Scoreboard bench for stream_pixel_framer: the stimulus side pushes the
// expected tagged beat for every accepted pixel, a negedge monitor pops and
// compares each output handshake and tracks frame_done/busy timing.
module tb_stream_pixel_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] cfg_cols, cfg_rows;
    logic        cfg_start;
    logic        busy, frame_done;
    logic [23:0] stream_in;
    logic        stream_in_valid, stream_in_ready;
    logic [23:0] stream_out;
    logic        stream_out_sof, stream_out_eol, stream_out_eof;
    logic        stream_out_valid, stream_out_ready;

    always #5 clk = ~clk;

    stream_pixel_framer dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_cols         (cfg_cols),
        .cfg_rows         (cfg_rows),
        .cfg_start        (cfg_start),
        .busy             (busy),
        .frame_done       (frame_done),
        .stream_in        (stream_in),
        .stream_in_valid  (stream_in_valid),
        .stream_in_ready  (stream_in_ready),
        .stream_out       (stream_out),
        .stream_out_sof   (stream_out_sof),
        .stream_out_eol   (stream_out_eol),
        .stream_out_eof   (stream_out_eof),
        .stream_out_valid (stream_out_valid),
        .stream_out_ready (stream_out_ready)
    );

    typedef struct packed {
        logic [23:0] data;
        logic        sof;
        logic        eol;
        logic        eof;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] src_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_cols = 0, m_rows = 0, m_total = 0, m_idx = 0;
    bit m_active = 0, m_can_start = 1;
    int m_frames_done = 0;

    // Monitor state
    bit   done_pending = 0, busy_due = 0, prev_stall = 0;
    exp_t prev_beat;
    int   mcyc = 0, sof_cyc = 0, eof_cyc = 0;

    // Stimulus controls
    int cyc = 0;
    int out_mode = 0;
    int gap_mode = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void note_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s actual=occurred required=not-occurring (t=%0t)", name, $time);
    endfunction

    // Model, scoreboard producer and output monitor, all sampled at negedge.
    always @(negedge clk) begin
        exp_t act, e;
        mcyc++;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (busy_due) begin
                chk("busy_after_start", 64'(busy), 64'd1);
                busy_due = 0;
            end
            if (cfg_start && m_can_start && cfg_cols != 0 && cfg_rows != 0) begin
                m_cols      = int'(cfg_cols);
                m_rows      = int'(cfg_rows);
                m_total     = m_cols * m_rows;
                m_idx       = 0;
                m_active    = 1;
                m_can_start = 0;
                busy_due    = 1;
            end
            if (stream_in_valid && stream_in_ready) begin
                if (!m_active) begin
                    note_fail("accept_outside_frame");
                end else begin
                    e.data = stream_in;
                    e.sof  = (m_idx == 0);
                    e.eol  = ((m_idx % m_cols) == m_cols - 1);
                    e.eof  = (m_idx == m_total - 1);
                    exp_q.push_back(e);
                    m_idx++;
                    if (m_idx == m_total) m_active = 0;
                end
                if (src_q.size() > 0) void'(src_q.pop_front());
            end

            act = {stream_out, stream_out_sof, stream_out_eol, stream_out_eof};
            if (prev_stall) begin
                chk("stall_valid_held", 64'(stream_out_valid), 64'd1);
                chk("stall_beat_held", 64'(act), 64'(prev_beat));
            end
            if (done_pending) begin
                chk("frame_done_pulse", 64'(frame_done), 64'd1);
                chk("busy_at_done", 64'(busy), 64'd0);
                done_pending = 0;
                m_frames_done++;
                m_can_start = 1;
            end else begin
                chk("frame_done_quiet", 64'(frame_done), 64'd0);
            end
            if (stream_out_valid && stream_out_ready) begin
                if (exp_q.size() == 0) begin
                    note_fail("unexpected_beat");
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 64'(act), 64'(e));
                    if (e.sof) sof_cyc = mcyc;
                    if (e.eof) begin
                        eof_cyc      = mcyc;
                        done_pending = 1;
                    end
                end
            end
            prev_stall = stream_out_valid && !stream_out_ready;
            prev_beat  = act;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        cfg_start = 1'b0;
        if (src_q.size() > 0 && (gap_mode == 0 || $urandom_range(0, 3) != 0)) begin
            stream_in_valid = 1'b1;
            stream_in       = src_q[0];
        end else begin
            stream_in_valid = 1'b0;
        end
        case (out_mode)
            0:       stream_out_ready = 1'b1;
            1:       stream_out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: stream_out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic clear_src();
        src_q.delete();
        stream_in_valid = 1'b0;
        stream_in       = '0;
    endtask

    task automatic start_frame(input int c, input int r);
        cfg_cols  = 12'(c);
        cfg_rows  = 12'(r);
        cfg_start = 1'b1;
        tick();
    endtask

    task automatic run_to_done(input int budget);
        int d0 = m_frames_done;
        int n  = 0;
        while (m_frames_done == d0 && n < budget) begin
            tick();
            n++;
        end
        if (m_frames_done == d0) note_fail("frame_timeout");
    endtask

    task automatic run_frame(input int c, input int r, input int omode, input int gap,
                             input int extra, input bit seq);
        for (int k = 0; k < c * r + extra; k++)
            src_q.push_back(seq ? 24'(k + 1) : 24'($urandom));
        out_mode = omode;
        gap_mode = gap;
        start_frame(c, r);
        run_to_done(4000);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        chk("pixels_consumed", 64'(m_idx), 64'(c * r));
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_stream_out"}, 64'(stream_out), 64'd0);
        chk({tag, "_flags"}, 64'({stream_out_sof, stream_out_eol, stream_out_eof}), 64'd0);
        chk({tag, "_out_valid"}, 64'(stream_out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(stream_in_ready), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        cfg_cols = '0;
        cfg_rows = '0;
        cfg_start = 1'b0;
        stream_in = '0;
        stream_in_valid = 1'b0;
        stream_out_ready = 1'b1;
        tick();
        tick();
        chk_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // 4x2, full throughput
        run_frame(4, 2, 0, 0, 0, 0);
        chk("throughput_4x2", 64'(eof_cyc - sof_cyc), 64'd7);
        chk("busy_after_frame", 64'(busy), 64'd0);
        clear_src();
        tick();

        // 4x2 with output ready pattern 1,0,0,1
        run_frame(4, 2, 1, 0, 0, 0);
        clear_src();
        tick();

        // 3x1 with two pixels of trailing padding
        run_frame(3, 1, 0, 0, 2, 1);
        tick();
        tick();
        chk("padding_not_accepted", 64'(stream_in_ready), 64'd0);
        chk("padding_left_upstream", 64'(src_q.size()), 64'd2);
        chk("padding_head_value", 64'(src_q[0]), 64'h4);
        clear_src();
        tick();

        // zero geometry is ignored
        src_q.push_back(24'hABCDEF);
        start_frame(0, 3);
        start_frame(5, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("zero_cfg_busy", 64'(busy), 64'd0);
        chk("zero_cfg_ready", 64'(stream_in_ready), 64'd0);
        chk("zero_cfg_src_kept", 64'(src_q.size()), 64'd1);
        clear_src();
        tick();

        // cfg_start during RUN must not alter the running 4x2 frame
        for (int k = 0; k < 8; k++) src_q.push_back(24'($urandom));
        out_mode = 1;
        gap_mode = 0;
        start_frame(4, 2);
        n = 0;
        while (m_idx < 3 && n < 100) begin
            tick();
            n++;
        end
        start_frame(2, 2);
        run_to_done(1000);
        chk("run_cfg_ignored_drained", 64'(exp_q.size()), 64'd0);
        chk("run_cfg_ignored_count", 64'(m_idx), 64'd8);
        clear_src();
        tick();

        // reset after 5 of 16 pixels, then a clean 4x4 frame
        for (int k = 0; k < 16; k++) src_q.push_back(24'($urandom));
        out_mode = 0;
        start_frame(4, 4);
        n = 0;
        while (m_idx < 5 && n < 100) begin
            tick();
            n++;
        end
        chk("pixels_before_reset", 64'(m_idx), 64'd5);
        rst = 1'b1;
        exp_q.delete();
        m_active = 0;
        m_idx = 0;
        m_can_start = 1;
        done_pending = 0;
        busy_due = 0;
        clear_src();
        tick();
        chk_outputs_zero("midframe_reset");
        rst = 1'b0;
        tick();
        run_frame(4, 4, 2, 1, 0, 0);
        clear_src();
        tick();

        // 1x1 single beat carries all three tags
        run_frame(1, 1, 0, 0, 1, 0);
        chk("single_beat_span", 64'(eof_cyc - sof_cyc), 64'd0);
        clear_src();
        tick();

        // randomized geometries, gaps and backpressure
        for (int f = 0; f < 6; f++) begin
            run_frame(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)), 2, 1,
                      int'($urandom_range(0, 2)), 0);
            clear_src();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
